spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
Serial front end of the SPI memory slave. It deserialises MOSI frames into 10-bit command/data words, which it presents on rx_data with a one-cycle rx_valid strobe to the downstream memory stage. For read-data frames it waits for the memory's tx_valid/tx_data response and serialises the 8-bit byte onto MISO. SPI SCK is the system clk; all I/O is sampled and driven on its rising edge.

Parameters:
FRAME_W, 10, width of rx_data word (2-bit opcode + 8-bit payload)
DATA_W, 8, width of tx_data byte returned on MISO
TX_TIMEOUT, 16, max cycles waiting for tx_valid (used only with optional feature)

Ports:
clk  input  1  system/SPI clock, rising edge
rst_n  input  1  asynchronous active-low reset
ss_n  input  1  slave select, active low; high aborts/ends frame
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first
rx_data  output  FRAME_W  deserialised word {opcode[1:0], payload[7:0]}
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  DATA_W  read byte from memory stage
tx_valid  input  1  tx_data valid (may stay high for several cycles)
timeout_err  output  1  one-cycle strobe on read timeout; tied 0 when feature disabled

Behaviour:
- Reset (rst_n=0, async): state=IDLE, miso=0, rx_data=0, rx_valid=0, timeout_err=0, rd_addr_done=0, bit counter=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: ss_n=0 -> CHK_CMD. No mosi bit is consumed here.
- CHK_CMD: samples mosi as the command bit and does not shift it in. mosi=0 -> WRITE; mosi=1 and rd_addr_done=0 -> READ_ADD; mosi=1 and rd_addr_done=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift FRAME_W mosi bits MSB-first, one per clk.
  - On the edge sampling the 10th bit, rx_data is loaded and rx_valid is set for exactly one cycle.
  - The opcode in rx_data[9:8] is passed through unchecked.
- READ_ADD: on frame completion, rd_addr_done<=1; then hold until ss_n=1.
- READ_DATA: after rx_valid, enter the tx-wait phase.
  - Capture tx_data on the first edge where tx_valid=1; later tx_valid highs are ignored.
  - miso presents tx_data[7] in the cycle after capture, then bits [6:0] on the following 7 cycles.
  - After the 8th bit: miso=0 and rd_addr_done<=0; hold until ss_n=1.
- miso=0 whenever not actively serialising.
- ss_n=1 in any state -> IDLE on next edge.
  - Bit counter is cleared and the partial frame is discarded, with no rx_valid.
  - Serialisation is aborted and miso=0.
  - rd_addr_done is cleared only if the read-data byte completed; it is retained otherwise.
- Extra mosi bits after a frame completes are ignored until ss_n=1.
- Bit counter is $clog2(FRAME_W) bits wide; it never wraps within a frame.

Optional Feature:
SPI_SLAVE_TX_TIMEOUT_EN
- Defined: in the tx-wait phase, a counter is loaded with TX_TIMEOUT. If tx_valid is not seen before it reaches 0:
  - timeout_err pulses one cycle;
  - the state goes to a hold state (miso=0) until ss_n=1;
  - rd_addr_done is cleared.
- Undefined: the block waits for tx_valid indefinitely; timeout_err is constant 0; no counter logic is synthesised.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum spi_state_e;
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - default FRAME_W/DATA_W.
- Sub-module spi_miso_serializer (load, din[DATA_W-1:0] -> miso, busy, done) owns the TX shift register and bit counter. The FSM and RX shifting stay in spi_slave_if.

Test Plan:
- Write address: ss_n=0, mosi=0, then 00_0000_1010 -> rx_data=10'h00A, rx_valid high 1 cycle on the edge after the 10th bit; miso stays 0.
- Write data: mosi=0, then 01_1010_0101 -> rx_data=10'h1A5, rx_valid 1 cycle; rd_addr_done unchanged.
- Read sequence: frame 1 is mosi=1, 10_0000_1010 -> rx_data=10'h20A. Deassert ss_n, then frame 2 is mosi=1, 11_0000_0000 -> rx_data=10'h300. Drive tx_data=8'hA5, tx_valid=1 the next cycle -> miso=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
- Abort: ss_n rises after 5 data bits -> no rx_valid, state IDLE. The next full write frame 10'h0FF is received correctly.
- Read-data without prior address, after reset: mosi=1 -> READ_ADD path taken, rd_addr_done=1 after the frame, miso never toggles.
- With SPI_SLAVE_TX_TIMEOUT_EN: read-data frame, tx_valid held 0 -> timeout_err pulses at cycle TX_TIMEOUT (16) after rx_valid; miso stays 0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_pkg
//  Description : Shared types and constants for the SPI memory slave front
//                end: FSM state encoding, command opcodes, default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    localparam int DEF_FRAME_W = 10;
    localparam int DEF_DATA_W  = 8;

    // Opcodes carried in rx_data[9:8]; the front end forwards them unchecked.
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // TX_WAIT / TX_SEND / HOLD are the sub-phases that follow a completed
    // frame: waiting for the memory byte, shifting it out, and parking until
    // slave select is released.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        TX_WAIT   = 3'd5,
        TX_SEND   = 3'd6,
        HOLD      = 3'd7
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_miso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_miso_serializer
//  Description : Shifts one DATA_W byte out on miso, MSB first. The MSB
//                appears in the cycle right after load; done flags the edge
//                on which the last bit retires (combinational).
//  Ports       : clk, rst_n (async, active low), clear (abort, miso->0),
//                load/din (start a byte), miso, busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_miso_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              miso,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bits_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            miso      <= 1'b0;
        end else if (clear) begin
            bits_left <= '0;
            busy      <= 1'b0;
            miso      <= 1'b0;
        end else if (load) begin
            // MSB goes straight to the pin; the rest queue up behind it.
            shreg     <= {din[DATA_W-2:0], 1'b0};
            miso      <= din[DATA_W-1];
            bits_left <= CNT_W'(DATA_W - 1);
            busy      <= 1'b1;
        end else if (busy) begin
            if (bits_left == '0) begin
                busy <= 1'b0;
                miso <= 1'b0;
            end else begin
                miso      <= shreg[DATA_W-1];
                shreg     <= {shreg[DATA_W-2:0], 1'b0};
                bits_left <= bits_left - 1'b1;
            end
        end
    end

    assign done = busy && (bits_left == '0);

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : SPI slave serial front end. Deserialises MOSI frames into
//                {opcode, payload} words (rx_data/rx_valid) and, for
//                read-data frames, serialises the memory's tx_data onto MISO.
//  Ports       : clk, rst_n (async, active low), ss_n, mosi, miso,
//                rx_data[FRAME_W-1:0], rx_valid, tx_data[DATA_W-1:0],
//                tx_valid, timeout_err
//  Options     : SPI_SLAVE_TX_TIMEOUT_EN - bounded wait for tx_valid with a
//                timeout_err pulse; otherwise the wait is unbounded and
//                timeout_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TX_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               timeout_err
);

    localparam int               CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    if (FRAME_W < 3 || DATA_W < 2 || TX_TIMEOUT < 1) begin : g_param_check
        $error("spi_slave_if: unsupported parameter combination");
    end

    spi_state_e           state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_W-2:0]   rx_shift;
    logic                 rd_addr_done;

    logic                 shifting;
    logic                 frame_done;
    logic                 rd_done_set;
    logic                 rd_done_clr;
    logic                 ser_load;
    logic                 ser_busy;
    logic                 ser_done;
    logic                 tmo_hit;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        shifting    = 1'b0;
        frame_done  = 1'b0;
        rd_done_set = 1'b0;
        rd_done_clr = 1'b0;
        ser_load    = 1'b0;
        if (ss_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CHK_CMD;
                CHK_CMD: begin
                    // Command bit steers the frame but is not part of rx_data.
                    if (!mosi)             state_nxt = WRITE;
                    else if (rd_addr_done) state_nxt = READ_DATA;
                    else                   state_nxt = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    shifting = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        frame_done  = 1'b1;
                        rd_done_set = (state == READ_ADD);
                        state_nxt   = (state == READ_DATA) ? TX_WAIT : HOLD;
                    end
                end
                TX_WAIT: begin
                    if (tx_valid) begin
                        ser_load  = 1'b1;
                        state_nxt = TX_SEND;
                    end else if (tmo_hit) begin
                        rd_done_clr = 1'b1;
                        state_nxt   = HOLD;
                    end
                end
                TX_SEND: begin
                    if (ser_done || !ser_busy) begin
                        rd_done_clr = 1'b1;
                        state_nxt   = HOLD;
                    end
                end
                HOLD:    state_nxt = HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX deserialiser and read-address tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            if (frame_done) begin
                rx_data <= {rx_shift, mosi};
                bit_cnt <= '0;
            end else if (shifting) begin
                rx_shift <= {rx_shift[FRAME_W-3:0], mosi};
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                // Covers ss_n aborts: a partial frame is simply dropped.
                bit_cnt <= '0;
            end
            if (rd_done_set)      rd_addr_done <= 1'b1;
            else if (rd_done_clr) rd_addr_done <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    spi_miso_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ss_n),
        .load  (ser_load),
        .din   (tx_data),
        .miso  (miso),
        .busy  (ser_busy),
        .done  (ser_done)
    );

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TX_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;

    // Loaded on every frame completion; only counts while in TX_WAIT, so a
    // stale value after a write frame is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= !ss_n && (state == TX_WAIT) && !tx_valid && tmo_hit;
            if (frame_done)
                tmo_cnt <= TMO_W'(TX_TIMEOUT);
            else if (state == TX_WAIT && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // Expiry is the edge on which the counter steps from 1 to 0.
    assign tmo_hit     = (tmo_cnt == TMO_W'(1));
    assign timeout_err = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_if
//  Description : Directed self-checking bench for spi_slave_if. Inputs are
//                driven and outputs observed on the falling clock edge.
//                Honours SPI_SLAVE_TX_TIMEOUT_EN for the timeout scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;
    import spi_slave_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_slave_if #(
        .FRAME_W    (10),
        .DATA_W     (8),
        .TX_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .timeout_err (timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a falling edge with the DUT idle; returns at the falling edge
    // right after the edge that sampled the last data bit.
    task automatic send_frame(input logic cmd, input logic [9:0] word, input string tag);
        logic miso_seen;
        logic early_valid;
        miso_seen   = 1'b0;
        early_valid = 1'b0;
        ss_n = 1'b0;
        mosi = 1'b0;
        @(negedge clk);
        mosi = cmd;
        @(negedge clk);
        early_valid |= rx_valid;
        for (int i = 9; i >= 0; i--) begin
            mosi = word[i];
            @(negedge clk);
            miso_seen |= miso;
            if (i != 0) early_valid |= rx_valid;
        end
        mosi = 1'b0;
        check_eq({tag, "_early_valid"}, 32'(early_valid), 32'd0);
        check_eq({tag, "_rx_valid"},    32'(rx_valid),    32'd1);
        check_eq({tag, "_rx_data"},     32'(rx_data),     32'(word));
        check_eq({tag, "_miso_quiet"},  32'(miso_seen),   32'd0);
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] tx_byte;
        logic       miso_seen;
        logic       valid_seen;

        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check_eq("rst_miso",        32'(miso),             32'd0);
        check_eq("rst_rx_data",     32'(rx_data),          32'd0);
        check_eq("rst_rx_valid",    32'(rx_valid),         32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err),      32'd0);
        check_eq("rst_state",       32'(dut.state),        32'(IDLE));
        check_eq("rst_rd_addr",     32'(dut.rd_addr_done), 32'd0);

        // Write address, then trailing mosi bits that must be ignored
        send_frame(1'b0, {OP_WR_ADDR, 8'h0A}, "wr_addr");
        mosi = 1'b1;
        @(negedge clk);
        check_eq("wr_addr_valid_1cyc", 32'(rx_valid), 32'd0);
        valid_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            valid_seen |= rx_valid;
        end
        check_eq("wr_addr_extra_bits", 32'(valid_seen),        32'd0);
        check_eq("wr_addr_rd_done",    32'(dut.rd_addr_done),  32'd0);
        end_frame();

        // Write data
        send_frame(1'b0, {OP_WR_DATA, 8'hA5}, "wr_data");
        @(negedge clk);
        check_eq("wr_data_valid_1cyc", 32'(rx_valid),         32'd0);
        check_eq("wr_data_rd_done",    32'(dut.rd_addr_done), 32'd0);
        end_frame();

        // Read address
        send_frame(1'b1, {OP_RD_ADDR, 8'h0A}, "rd_addr");
        check_eq("rd_addr_done_set", 32'(dut.rd_addr_done), 32'd1);
        end_frame();
        check_eq("rd_addr_done_kept", 32'(dut.rd_addr_done), 32'd1);

        // Read data: A5 out on miso; a later tx_valid with other data is ignored
        send_frame(1'b1, {OP_RD_DATA, 8'h00}, "rd_data");
        check_eq("rd_data_state", 32'(dut.state), 32'(TX_WAIT));
        tx_byte  = 8'hA5;
        tx_data  = tx_byte;
        tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            if (i == 7) tx_data = 8'h3C;
            check_eq($sformatf("rd_data_miso_b%0d", i), 32'(miso), 32'(tx_byte[i]));
        end
        @(negedge clk);
        check_eq("rd_data_miso_after", 32'(miso),             32'd0);
        check_eq("rd_data_rd_cleared", 32'(dut.rd_addr_done), 32'd0);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        end_frame();

        // Abort after 5 data bits, then a clean write of 0x0FF
        ss_n = 1'b0;
        @(negedge clk);
        mosi = 1'b0;
        @(negedge clk);
        valid_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            @(negedge clk);
            valid_seen |= rx_valid;
        end
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        valid_seen |= rx_valid;
        check_eq("abort_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        valid_seen |= rx_valid;
        check_eq("abort_no_valid", 32'(valid_seen), 32'd0);
        send_frame(1'b0, 10'h0FF, "post_abort");
        end_frame();

        // Read-data command straight after reset goes down the address path
        do_reset();
        send_frame(1'b1, {OP_RD_DATA, 8'hAB}, "rd_noaddr");
        check_eq("rd_noaddr_rd_done", 32'(dut.rd_addr_done), 32'd1);
        check_eq("rd_noaddr_state",   32'(dut.state),        32'(HOLD));
        tx_data   = 8'hFF;
        tx_valid  = 1'b1;
        miso_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            miso_seen |= miso;
        end
        check_eq("rd_noaddr_miso_quiet", 32'(miso_seen), 32'd0);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        end_frame();

        // Read data with no memory response
        send_frame(1'b1, {OP_RD_DATA, 8'h11}, "rd_wait");
        miso_seen = 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            miso_seen |= miso;
            if (k == 15) check_eq("tmo_early", 32'(timeout_err), 32'd0);
            if (k == 16) check_eq("tmo_pulse", 32'(timeout_err), 32'd1);
            if (k == 17) check_eq("tmo_1cyc",  32'(timeout_err), 32'd0);
        end
        check_eq("tmo_miso_quiet", 32'(miso_seen),         32'd0);
        check_eq("tmo_rd_cleared", 32'(dut.rd_addr_done),  32'd0);
        check_eq("tmo_state",      32'(dut.state),         32'(HOLD));
`else
        valid_seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            miso_seen  |= miso;
            valid_seen |= timeout_err;
        end
        check_eq("notmo_err_low",    32'(valid_seen),        32'd0);
        check_eq("notmo_miso_quiet", 32'(miso_seen),         32'd0);
        check_eq("notmo_state",      32'(dut.state),         32'(TX_WAIT));
        check_eq("notmo_rd_kept",    32'(dut.rd_addr_done),  32'd1);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("notmo_late_b7", 32'(miso), 32'd1);
        @(negedge clk);
        check_eq("notmo_late_b6", 32'(miso), 32'd0);
`endif
        end_frame();
        check_eq("final_miso", 32'(miso), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
